// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: bus widths, ms_to_ws_bus field offsets and load-op
// encodings.
package cpu_pkg;

  localparam int unsigned MS_BUS_W  = 75;
  localparam int unsigned FWD_BUS_W = 38;

  // ms_to_ws_bus layout, MSB first: {pc, gr_we, dest, res, ld_op, addr_lo}
  localparam int unsigned MS_ADDR_LO_LSB = 0;
  localparam int unsigned MS_LD_OP_LSB   = 2;
  localparam int unsigned MS_RES_LSB     = 5;
  localparam int unsigned MS_DEST_LSB    = 37;
  localparam int unsigned MS_GR_WE_BIT   = 42;
  localparam int unsigned MS_PC_LSB      = 43;

  localparam logic [2:0] LD_OP_W  = 3'b000;
  localparam logic [2:0] LD_OP_B  = 3'b001;
  localparam logic [2:0] LD_OP_H  = 3'b010;
  localparam logic [2:0] LD_OP_BU = 3'b011;
  localparam logic [2:0] LD_OP_HU = 3'b100;

endpackage

// File: rtl/load_align.sv
// Combinational load-data alignment: selects the addressed byte or half of the raw result and
// sign- or zero-extends it. Word loads and unused encodings pass the result through.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] res_i,
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select; addr_lo[0] is ignored for halves since misalignment traps upstream.
  always_comb begin
    unique case (addr_lo_i)
      2'd0:    byte_sel = res_i[7:0];
      2'd1:    byte_sel = res_i[15:8];
      2'd2:    byte_sel = res_i[23:16];
      default: byte_sel = res_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? res_i[31:16] : res_i[15:0];
  end

  // Extension by load type.
  always_comb begin
    case (ld_op_i)
      LD_OP_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_OP_H:  data_o = {{16{half_sel[15]}}, half_sel};
      LD_OP_BU: data_o = {24'd0, byte_sel};
      LD_OP_HU: data_o = {16'd0, half_sel};
      default:  data_o = res_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers one instruction from MEM over a valid/allowin handshake, aligns load
// data and drives the register-file write port, the decode forwarding bus and a retire counter.
// Optional feature macro: DEBUG_TRACE_EN adds the debug_wb_* trace ports and stores the pc field.
module wb_stage
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ms_to_ws_valid,
  input  logic [MS_BUS_W-1:0]  ms_to_ws_bus,
  output logic                 ws_allowin,
  input  logic                 wb_hold,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [FWD_BUS_W-1:0] ws_fwd_bus,
`ifdef DEBUG_TRACE_EN
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata,
`endif
  output logic [31:0]          retire_cnt
);

  logic        ws_valid_q, ws_valid_d;
  logic        gr_we_q, gr_we_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] res_q, res_d;
  logic [2:0]  ld_op_q, ld_op_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
`ifdef DEBUG_TRACE_EN
  logic [31:0] pc_q, pc_d;
`endif

  logic        ws_ready_go;
  logic        load_payload;
  logic        writes_rf;
  logic [31:0] aligned_data;

  // Handshake, payload capture and retirement counting.
  always_comb begin
    ws_ready_go  = !wb_hold;
    ws_allowin   = !ws_valid_q || ws_ready_go;
    load_payload = ms_to_ws_valid && ws_allowin;

    ws_valid_d   = ws_allowin ? ms_to_ws_valid : ws_valid_q;
    gr_we_d      = gr_we_q;
    dest_d       = dest_q;
    res_d        = res_q;
    ld_op_d      = ld_op_q;
    addr_lo_d    = addr_lo_q;
`ifdef DEBUG_TRACE_EN
    pc_d         = pc_q;
`endif
    if (load_payload) begin
      gr_we_d   = ms_to_ws_bus[MS_GR_WE_BIT];
      dest_d    = ms_to_ws_bus[MS_DEST_LSB +: 5];
      res_d     = ms_to_ws_bus[MS_RES_LSB +: 32];
      ld_op_d   = ms_to_ws_bus[MS_LD_OP_LSB +: 3];
      addr_lo_d = ms_to_ws_bus[MS_ADDR_LO_LSB +: 2];
`ifdef DEBUG_TRACE_EN
      pc_d      = ms_to_ws_bus[MS_PC_LSB +: 32];
`endif
    end

    // Every retirement counts, including dest=0 and non-writing instructions.
    retire_cnt_d = retire_cnt_q + {31'd0, ws_valid_q && ws_ready_go};
  end

  // Stage registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid_q   <= 1'b0;
      gr_we_q      <= 1'b0;
      dest_q       <= 5'd0;
      res_q        <= 32'd0;
      ld_op_q      <= 3'd0;
      addr_lo_q    <= 2'd0;
      retire_cnt_q <= 32'd0;
`ifdef DEBUG_TRACE_EN
      pc_q         <= 32'd0;
`endif
    end else begin
      ws_valid_q   <= ws_valid_d;
      gr_we_q      <= gr_we_d;
      dest_q       <= dest_d;
      res_q        <= res_d;
      ld_op_q      <= ld_op_d;
      addr_lo_q    <= addr_lo_d;
      retire_cnt_q <= retire_cnt_d;
`ifdef DEBUG_TRACE_EN
      pc_q         <= pc_d;
`endif
    end
  end

  load_align u_load_align (
    .res_i     (res_q),
    .ld_op_i   (ld_op_q),
    .addr_lo_i (addr_lo_q),
    .data_o    (aligned_data)
  );

  // Register-file write and forwarding; forwarding ignores hold because the data is already final.
  always_comb begin
    writes_rf  = ws_valid_q && gr_we_q && (dest_q != 5'd0);
    rf_we      = writes_rf && ws_ready_go;
    rf_waddr   = dest_q;
    rf_wdata   = aligned_data;
    ws_fwd_bus = {writes_rf, dest_q, aligned_data};
    retire_cnt = retire_cnt_q;
  end

`ifdef DEBUG_TRACE_EN
  // Debug trace mirrors the write port.
  always_comb begin
    debug_wb_pc       = pc_q;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic. Expected writes are queued when
// an instruction is issued; a negedge monitor pops and compares them against the write port.
module tb_wb_stage;
  import cpu_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 ms_to_ws_valid = 1'b0;
  logic [MS_BUS_W-1:0]  ms_to_ws_bus = '0;
  logic                 ws_allowin;
  logic                 wb_hold = 1'b0;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [31:0]          rf_wdata;
  logic [FWD_BUS_W-1:0] ws_fwd_bus;
  logic [31:0]          retire_cnt;
`ifdef DEBUG_TRACE_EN
  logic [31:0]          debug_wb_pc;
  logic [3:0]           debug_wb_rf_we;
  logic [4:0]           debug_wb_rf_wnum;
  logic [31:0]          debug_wb_rf_wdata;
`endif

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .wb_hold           (wb_hold),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_bus        (ws_fwd_bus),
`ifdef DEBUG_TRACE_EN
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
`endif
    .retire_cnt        (retire_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          we_pulses = 0;
  logic [31:0] exp_cnt = 32'd0;
  bit          rand_hold = 1'b0;
  logic [36:0] exp_q[$];  // {dest, data} of every instruction expected to write the regfile

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference alignment from the load rules, using shifts and masks.
  function automatic logic [31:0] ref_align(input logic [31:0] res, input logic [2:0] op,
                                            input logic [1:0] lo);
    logic [31:0] b, h;
    b = (res >> (8 * lo)) & 32'hFF;
    h = (res >> (lo[1] ? 16 : 0)) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return res;
    endcase
  endfunction

  function automatic logic [MS_BUS_W-1:0] pack(input logic [31:0] pc, input logic we,
                                               input logic [4:0] dest, input logic [31:0] res,
                                               input logic [2:0] op, input logic [1:0] lo);
    return {pc, we, dest, res, op, lo};
  endfunction

  // Present one instruction and wait (bounded) until the stage takes it.
  task automatic issue(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                       input logic [31:0] res, input logic [2:0] op, input logic [1:0] lo,
                       input logic [31:0] exp_data);
    bit acc;
    acc = 1'b0;
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = pack(pc, we, dest, res, op, lo);
    if (we && dest != 5'd0) exp_q.push_back({dest, exp_data});
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = ws_allowin;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL accept_timeout: got not-accepted, expected accepted within 64 cycles");
    end
    exp_cnt++;
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    ms_to_ws_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: forwarding must show the oldest pending writer; each rf_we pops one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (ws_fwd_bus[37]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL fwd_unexpected: got fwd_valid=1 dest=%0d, expected no pending writer",
                   ws_fwd_bus[36:32]);
        end else if (ws_fwd_bus[36:0] !== exp_q[0]) begin
          failures++;
          $display("FAIL fwd_bus: got dest=%0d data=%h, expected dest=%0d data=%h",
                   ws_fwd_bus[36:32], ws_fwd_bus[31:0], exp_q[0][36:32], exp_q[0][31:0]);
        end
      end
      if (rf_we) begin
        we_pulses++;
        checks++;
        if (wb_hold) begin
          failures++;
          $display("FAIL write_while_held: got rf_we=1, expected 0 under wb_hold");
        end
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rf_unexpected: got write dest=%0d data=%h, expected none",
                   rf_waddr, rf_wdata);
        end else begin
          if ({rf_waddr, rf_wdata} !== exp_q[0]) begin
            failures++;
            $display("FAIL rf_write: got dest=%0d data=%h, expected dest=%0d data=%h",
                     rf_waddr, rf_wdata, exp_q[0][36:32], exp_q[0][31:0]);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Random debug-halt generator, active only during randomized traffic.
  always @(posedge clk) begin
    #1;
    if (rand_hold) wb_hold = ($urandom_range(0, 3) == 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    logic [31:0] r;
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [4:0]  d;
    logic        w;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_allowin", {31'd0, ws_allowin}, 32'd1);
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_fwd_valid", {31'd0, ws_fwd_bus[37]}, 32'd0);
    chk("reset_retire_cnt", retire_cnt, 32'd0);
    reset = 1'b0;

    // Reset pulse while a writer sits in the stage drops outputs before any edge.
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = pack(32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF, LD_OP_W, 2'd0);
    @(posedge clk);
    #1;
    ms_to_ws_valid = 1'b0;
    chk("pre_async_rf_we", {31'd0, rf_we}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rf_we", {31'd0, rf_we}, 32'd0);
    chk("async_fwd_valid", {31'd0, ws_fwd_bus[37]}, 32'd0);
    chk("async_allowin", {31'd0, ws_allowin}, 32'd1);
    chk("async_retire_cnt", retire_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Plain word writeback.
    issue(32'h1c00_0000, 1'b1, 5'd5, 32'h1234_5678, LD_OP_W, 2'd0, 32'h1234_5678);
    idle(2);
    chk("word_retire_cnt", retire_cnt, 32'd1);

    // Load alignment examples, back to back.
    issue(32'h4, 1'b1, 5'd1, 32'h80FF_7F01, LD_OP_B, 2'd3, 32'hFFFF_FF80);
    issue(32'h8, 1'b1, 5'd2, 32'h80FF_7F01, LD_OP_BU, 2'd1, 32'h0000_007F);
    issue(32'hC, 1'b1, 5'd3, 32'h80FF_7F01, LD_OP_H, 2'd2, 32'hFFFF_80FF);
    issue(32'h10, 1'b1, 5'd4, 32'h80FF_7F01, LD_OP_HU, 2'd0, 32'h0000_7F01);
    idle(2);
    chk("align_retire_cnt", retire_cnt, exp_cnt);

    // dest=0 retires but never writes.
    p0 = we_pulses;
    issue(32'h14, 1'b1, 5'd0, 32'h5555_5555, LD_OP_W, 2'd0, 32'h0);
    chk("dest0_rf_we", {31'd0, rf_we}, 32'd0);
    chk("dest0_fwd_valid", {31'd0, ws_fwd_bus[37]}, 32'd0);
    idle(2);
    chk("dest0_pulses", we_pulses - p0, 32'd0);
    chk("dest0_retire_cnt", retire_cnt, exp_cnt);

    // Hold with a waiting MEM instruction, then release.
    wb_hold = 1'b1;
    issue(32'h18, 1'b1, 5'd9, 32'hCAFE_F00D, LD_OP_W, 2'd0, 32'hCAFE_F00D);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = pack(32'h1C, 1'b1, 5'd10, 32'h0000_0081, LD_OP_B, 2'd0);
    exp_q.push_back({5'd10, 32'hFFFF_FF81});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_allowin", {31'd0, ws_allowin}, 32'd0);
      chk("hold_rf_we", {31'd0, rf_we}, 32'd0);
      chk("hold_fwd_valid", {31'd0, ws_fwd_bus[37]}, 32'd1);
      @(posedge clk);
      #1;
    end
    chk("hold_retire_cnt", retire_cnt, exp_cnt - 32'd1);
    wb_hold = 1'b0;
    @(negedge clk);
    chk("release_rf_we", {31'd0, rf_we}, 32'd1);
    chk("release_allowin", {31'd0, ws_allowin}, 32'd1);
    @(posedge clk);
    #1;
    ms_to_ws_valid = 1'b0;
    chk("release_retire_cnt", retire_cnt, exp_cnt);
    exp_cnt++;
    chk("release_next_dest", {27'd0, ws_fwd_bus[36:32]}, 32'd10);
    idle(2);

    // Three back-to-back writers give three consecutive pulses.
    p0 = we_pulses;
    issue(32'h20, 1'b1, 5'd11, 32'h1, LD_OP_W, 2'd0, 32'h1);
    issue(32'h24, 1'b1, 5'd12, 32'h2, LD_OP_W, 2'd0, 32'h2);
    issue(32'h28, 1'b1, 5'd13, 32'h3, LD_OP_W, 2'd0, 32'h3);
    @(negedge clk);
    chk("b2b_third_rf_we", {31'd0, rf_we}, 32'd1);
    chk("b2b_pulses_before_third", we_pulses - p0, 32'd2);
    idle(2);
    chk("b2b_pulses", we_pulses - p0, 32'd3);

    // Counter wraps.
    wb_hold = 1'b1;
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.retire_cnt_q;
    chk("preload_cnt", retire_cnt, 32'hFFFF_FFFF);
    wb_hold = 1'b0;
    exp_cnt = 32'hFFFF_FFFF;
    issue(32'h2C, 1'b0, 5'd1, 32'h0, LD_OP_W, 2'd0, 32'h0);
    idle(2);
    chk("wrap_cnt", retire_cnt, 32'd0);

    // Randomized traffic with random holds and gaps.
    rand_hold = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r  = $urandom;
      op = 3'($urandom_range(0, 7));
      lo = 2'($urandom_range(0, 3));
      d  = 5'($urandom_range(0, 31));
      w  = ($urandom_range(0, 4) != 0);
      issue($urandom, w, d, r, op, lo, ref_align(r, op, lo));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_hold = 1'b0;
    wb_hold   = 1'b0;
    idle(4);
    chk("rand_retire_cnt", retire_cnt, exp_cnt);
    chk("rand_queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
